timer_avm_sequencer: RTL and testbench

//  Avalon-MM master that drives the 16-bit interval-timer register slave without CPU involvement.
//  - Arms the timer and services its irq; clears the timeout flag on every tick.
//  - Optionally snapshots and reads back the timer counter on each tick.
//  - Exports tick pulses, a tick count and the snapshot value to fabric logic in the Qsys system.

---
 rtl/timer_avm_sequencer.sv | 175 +++++++++++++++++
 tb/tb_timer_avm_sequencer.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_avm_sequencer.sv
// timer_avm_sequencer
// Avalon-MM master that arms a 16-bit interval timer, services its timeout
// irq, optionally snapshots and reads back the timer counter after each
// timeout, and exports tick pulses, a tick count and the snapshot to fabric.
module timer_avm_sequencer #(
    parameter int DATA_W  = 16,
    parameter int TICK_W  = 32,
    parameter bit SNAP_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic              continuous,
    output logic              busy,
    output logic              tick,
    output logic [TICK_W-1:0] tick_count,
    output logic [DATA_W-1:0] snapshot,
    output logic              snapshot_valid,
    output logic [2:0]        avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              timer_irq
);

    // Timer register word addresses
    localparam logic [2:0] ADDR_STATUS  = 3'd0;
    localparam logic [2:0] ADDR_CONTROL = 3'd1;
    localparam logic [2:0] ADDR_SNAPL   = 3'd4;

    // CONTROL register bit positions
    localparam int CTRL_ITO   = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_WAIT,
        S_CLR,
        S_SNAPW,
        S_RADDR,
        S_RDATA,
        S_STOPW
    } state_t;

    state_t state;
    state_t state_next;
    logic   cont_q;
    logic   stop_pend;

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; a pending or live stop wins over irq in WAIT
    always_comb begin
        // NOTE: default assignment first so no path leaves state_next unassigned
        // (which would infer a latch).
        state_next = state;
        unique case (state)
            S_IDLE:  if (start) state_next = S_CFG;
            S_CFG:   state_next = S_WAIT;
            S_WAIT: begin
                if (stop || stop_pend) state_next = S_STOPW;
                else if (timer_irq)    state_next = S_CLR;
            end
            S_CLR: begin
                if (SNAP_EN)     state_next = S_SNAPW;
                else if (cont_q) state_next = S_WAIT;
                else             state_next = S_IDLE;
            end
            S_SNAPW: state_next = S_RADDR;
            S_RADDR: state_next = S_RDATA;
            S_RDATA: state_next = cont_q ? S_WAIT : S_IDLE;
            S_STOPW: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Session bookkeeping: mode latch, pending stop, tick counter, snapshot
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cont_q         <= 1'b0;
            stop_pend      <= 1'b0;
            tick_count     <= '0;
            snapshot       <= '0;
            snapshot_valid <= 1'b0;
        end else begin
            snapshot_valid <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        cont_q     <= continuous;
                        tick_count <= '0;
                    end
                end
                S_CLR: tick_count <= tick_count + TICK_W'(1);
                S_RDATA: begin
                    // Read data is valid this cycle; the pulse accompanies the
                    // updated snapshot value on the following cycle.
                    snapshot       <= avm_readdata;
                    snapshot_valid <= 1'b1;
                end
                default: ;
            endcase

            // A stop outside WAIT/IDLE is remembered; any return to IDLE
            // (STOPW or the one-shot path) and any accepted start drop it.
            if (state == S_IDLE) begin
                if (start) stop_pend <= 1'b0;
            end else if (state_next == S_IDLE) begin
                stop_pend <= 1'b0;
            end else if (stop && state != S_WAIT) begin
                stop_pend <= 1'b1;
            end
        end
    end

    // Bus and status outputs decoded from the current state only
    always_comb begin
        avm_chipselect = 1'b0;
        avm_write_n    = 1'b1;
        avm_address    = '0;
        avm_writedata  = '0;
        tick           = 1'b0;
        busy           = (state != S_IDLE);
        unique case (state)
            S_CFG: begin
                avm_chipselect            = 1'b1;
                avm_write_n               = 1'b0;
                avm_address               = ADDR_CONTROL;
                avm_writedata[CTRL_ITO]   = 1'b1;
                avm_writedata[CTRL_CONT]  = cont_q;
                avm_writedata[CTRL_START] = 1'b1;
            end
            S_CLR: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = ADDR_STATUS;
                tick           = 1'b1;
            end
            S_SNAPW: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = ADDR_SNAPL;
            end
            S_RADDR: begin
                avm_chipselect = 1'b1;
                avm_address    = ADDR_SNAPL;
            end
            S_RDATA: begin
                avm_address = ADDR_SNAPL;
            end
            S_STOPW: begin
                avm_chipselect           = 1'b1;
                avm_write_n              = 1'b0;
                avm_address              = ADDR_CONTROL;
                avm_writedata[CTRL_STOP] = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_timer_avm_sequencer.sv
// Testbench for timer_avm_sequencer: a behavioural timer slave logs every
// write and answers SNAPL reads with latency 1; each scenario compares the
// logged write sequence and exported status against expectations built
// from the register-level behaviour of a timer session.
module tb_timer_avm_sequencer;

    localparam int DATA_W = 16;
    localparam int TICK_W = 32;

    typedef logic [18:0] wr_t;   // {address[2:0], writedata[15:0]}

    logic              clk;
    logic              reset_n;
    logic              start;
    logic              stop;
    logic              continuous;
    logic              busy;
    logic              tick;
    logic [TICK_W-1:0] tick_count;
    logic [DATA_W-1:0] snapshot;
    logic              snapshot_valid;
    logic [2:0]        avm_address;
    logic              avm_chipselect;
    logic              avm_write_n;
    logic [DATA_W-1:0] avm_writedata;
    logic [DATA_W-1:0] avm_readdata;
    logic              timer_irq;

    int n_checks = 0;
    int n_pass   = 0;

    // Slave model state
    wr_t               wr_log[$];
    logic [DATA_W-1:0] counter_val = '0;
    logic [DATA_W-1:0] snap_latch;
    bit                prev_read4;
    int                clr_seen;
    int                sv_count;

    timer_avm_sequencer #(
        .DATA_W (DATA_W),
        .TICK_W (TICK_W),
        .SNAP_EN(1'b1)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .stop          (stop),
        .continuous    (continuous),
        .busy          (busy),
        .tick          (tick),
        .tick_count    (tick_count),
        .snapshot      (snapshot),
        .snapshot_valid(snapshot_valid),
        .avm_address   (avm_address),
        .avm_chipselect(avm_chipselect),
        .avm_write_n   (avm_write_n),
        .avm_writedata (avm_writedata),
        .avm_readdata  (avm_readdata),
        .timer_irq     (timer_irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // Timer slave: logs writes, latches counter on SNAPL write, returns it
    // one cycle after a SNAPL read is presented (garbage otherwise).
    initial begin
        avm_readdata = '0;
        snap_latch   = '0;
        prev_read4   = 1'b0;
        clr_seen     = 0;
        sv_count     = 0;
        forever begin
            @(negedge clk);
            if (prev_read4) avm_readdata = snap_latch;
            else            avm_readdata = DATA_W'($urandom);
            prev_read4 = (avm_chipselect === 1'b1) && (avm_write_n === 1'b1) &&
                         (avm_address === 3'd4);
            if (avm_chipselect === 1'b1 && avm_write_n === 1'b0) begin
                wr_log.push_back({avm_address, avm_writedata});
                if (avm_address === 3'd0) clr_seen++;
                if (avm_address === 3'd4) snap_latch = counter_val;
            end
            if (snapshot_valid === 1'b1) sv_count++;
        end
    end

    function automatic bit logs_equal(input wr_t a[$], input wr_t b[$]);
        if (a.size() != b.size()) return 1'b0;
        foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic cont);
        step();
        start      = 1'b1;
        continuous = cont;
        step();
        start      = 1'b0;
        continuous = $urandom_range(0, 1);
    endtask

    task automatic pulse_stop();
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    // Raise irq, drop it once the STATUS write appears, let the snapshot finish
    task automatic fire_irq(input logic [DATA_W-1:0] val, output bit ok,
                            output logic tick_at_clr);
        int c0;
        ok          = 1'b0;
        tick_at_clr = 1'b0;
        counter_val = val;
        c0          = clr_seen;
        timer_irq   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (clr_seen != c0) begin
                ok          = 1'b1;
                tick_at_clr = tick;
                break;
            end
        end
        timer_irq = 1'b0;
        repeat (5) step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; stop = 1'b0; continuous = 1'b0; timer_irq = 1'b0;
        step(); step();
        n_checks++;
        if ({avm_chipselect, avm_write_n, avm_address, avm_writedata} !== {1'b0, 1'b1, 3'd0, 16'h0})
            $display("FAIL reset_bus: got %h required %h",
                     {avm_chipselect, avm_write_n, avm_address, avm_writedata}, {1'b0, 1'b1, 3'd0, 16'h0});
        else n_pass++;
        n_checks++;
        if ({busy, tick, snapshot_valid} !== 3'b000)
            $display("FAIL reset_status: got busy/tick/sv=%b required 000", {busy, tick, snapshot_valid});
        else n_pass++;
        n_checks++;
        if (tick_count !== '0 || snapshot !== '0)
            $display("FAIL reset_counts: got tick_count=%h snapshot=%h required 0/0", tick_count, snapshot);
        else n_pass++;
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_periodic();
        wr_t exp[$];
        bit ok; logic tk; int sv0;
        logic [DATA_W-1:0] val;
        wr_log.delete();
        sv0 = sv_count;
        pulse_start(1'b1);
        n_checks++;
        if ({avm_chipselect, avm_write_n, avm_address, avm_writedata, busy} !== {1'b1, 1'b0, 3'd1, 16'h0007, 1'b1})
            $display("FAIL periodic_cfg: got cs/wn/addr/wd/busy=%h required %h",
                     {avm_chipselect, avm_write_n, avm_address, avm_writedata, busy},
                     {1'b1, 1'b0, 3'd1, 16'h0007, 1'b1});
        else n_pass++;
        step();
        n_checks++;
        if ({avm_chipselect, avm_write_n, avm_address, avm_writedata} !== {1'b0, 1'b1, 3'd0, 16'h0})
            $display("FAIL periodic_wait_idle: got %h required %h",
                     {avm_chipselect, avm_write_n, avm_address, avm_writedata}, {1'b0, 1'b1, 3'd0, 16'h0});
        else n_pass++;
        exp.push_back({3'd1, 16'h0007});
        for (int k = 1; k <= 3; k++) begin
            val = (k == 1) ? 16'h03E7 : DATA_W'($urandom);
            fire_irq(val, ok, tk);
            exp.push_back({3'd0, 16'h0});
            exp.push_back({3'd4, 16'h0});
            n_checks++;
            if (!ok || tk !== 1'b1)
                $display("FAIL periodic_tick%0d: got clr_seen=%0d tick=%b required 1/1", k, ok, tk);
            else n_pass++;
            n_checks++;
            if (snapshot !== val || tick_count !== TICK_W'(k))
                $display("FAIL periodic_snap%0d: got snapshot=%h tick_count=%0d required %h/%0d",
                         k, snapshot, tick_count, val, k);
            else n_pass++;
        end
        n_checks++;
        if (sv_count - sv0 != 3)
            $display("FAIL periodic_sv_pulses: got %0d required 3", sv_count - sv0);
        else n_pass++;
        pulse_stop();
        repeat (3) step();
        exp.push_back({3'd1, 16'h0008});
        n_checks++;
        if (busy !== 1'b0 || !logs_equal(wr_log, exp))
            $display("FAIL periodic_log: got busy=%b writes=%p required busy=0 writes=%p", busy, wr_log, exp);
        else n_pass++;
    endtask

    task automatic test_oneshot();
        wr_t exp[$];
        bit ok; logic tk;
        logic [DATA_W-1:0] val;
        wr_log.delete();
        pulse_start(1'b0);
        n_checks++;
        if ({avm_address, avm_writedata, tick_count} !== {3'd1, 16'h0005, 32'd0})
            $display("FAIL oneshot_cfg: got addr/wd/tick_count=%h required %h",
                     {avm_address, avm_writedata, tick_count}, {3'd1, 16'h0005, 32'd0});
        else n_pass++;
        val = DATA_W'($urandom);
        fire_irq(val, ok, tk);
        exp = '{{3'd1, 16'h0005}, {3'd0, 16'h0}, {3'd4, 16'h0}};
        n_checks++;
        if (!ok || busy !== 1'b0 || snapshot !== val || tick_count !== TICK_W'(1))
            $display("FAIL oneshot_end: got ok=%0d busy=%b snapshot=%h tick_count=%0d required 1/0/%h/1",
                     ok, busy, snapshot, tick_count, val);
        else n_pass++;
        n_checks++;
        if (!logs_equal(wr_log, exp))
            $display("FAIL oneshot_log: got %p required %p", wr_log, exp);
        else n_pass++;
    endtask

    task automatic test_stop_priority();
        wr_t exp[$];
        logic [DATA_W-1:0] val;
        // stop and irq together in WAIT: STOPW, no CLR
        wr_log.delete();
        pulse_start(1'b1);
        step();
        stop = 1'b1; timer_irq = 1'b1;
        step();
        stop = 1'b0;
        n_checks++;
        if ({avm_chipselect, avm_write_n, avm_address, avm_writedata, tick} !== {1'b1, 1'b0, 3'd1, 16'h0008, 1'b0})
            $display("FAIL stop_wins_bus: got %h required %h",
                     {avm_chipselect, avm_write_n, avm_address, avm_writedata, tick},
                     {1'b1, 1'b0, 3'd1, 16'h0008, 1'b0});
        else n_pass++;
        step();
        timer_irq = 1'b0;
        exp = '{{3'd1, 16'h0007}, {3'd1, 16'h0008}};
        n_checks++;
        if (busy !== 1'b0 || tick_count !== '0 || !logs_equal(wr_log, exp))
            $display("FAIL stop_wins_log: got busy=%b tick_count=%0d writes=%p required 0/0/%p",
                     busy, tick_count, wr_log, exp);
        else n_pass++;
        // stop during SNAPW: snapshot completes, then STOPW
        wr_log.delete();
        pulse_start(1'b1);
        step();
        val = DATA_W'($urandom);
        counter_val = val;
        timer_irq = 1'b1;
        step();
        timer_irq = 1'b0;
        step();
        n_checks++;
        if ({avm_chipselect, avm_write_n, avm_address} !== {1'b1, 1'b0, 3'd4})
            $display("FAIL snapw_bus: got %b required %b", {avm_chipselect, avm_write_n, avm_address}, 5'b10100);
        else n_pass++;
        stop = 1'b1;
        step();
        stop = 1'b0;
        n_checks++;
        if ({avm_chipselect, avm_write_n, avm_address} !== {1'b1, 1'b1, 3'd4})
            $display("FAIL raddr_bus: got %b required %b", {avm_chipselect, avm_write_n, avm_address}, 5'b11100);
        else n_pass++;
        repeat (5) step();
        exp = '{{3'd1, 16'h0007}, {3'd0, 16'h0}, {3'd4, 16'h0}, {3'd1, 16'h0008}};
        n_checks++;
        if (busy !== 1'b0 || snapshot !== val || tick_count !== TICK_W'(1) || !logs_equal(wr_log, exp))
            $display("FAIL stop_pend_log: got busy=%b snapshot=%h tick_count=%0d writes=%p required 0/%h/1/%p",
                     busy, snapshot, tick_count, wr_log, val, exp);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        pulse_start(1'b1);
        step();
        counter_val = DATA_W'($urandom);
        timer_irq = 1'b1;
        step();
        timer_irq = 1'b0;
        step(); step();
        reset_n = 1'b0;
        step();
        n_checks++;
        if ({avm_chipselect, avm_write_n, avm_address, avm_writedata, busy} !== {1'b0, 1'b1, 3'd0, 16'h0, 1'b0})
            $display("FAIL reset_mid: got %h required %h",
                     {avm_chipselect, avm_write_n, avm_address, avm_writedata, busy},
                     {1'b0, 1'b1, 3'd0, 16'h0, 1'b0});
        else n_pass++;
        n_checks++;
        if (tick_count !== '0 || snapshot_valid !== 1'b0)
            $display("FAIL reset_mid_counts: got tick_count=%0d sv=%b required 0/0", tick_count, snapshot_valid);
        else n_pass++;
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_start_busy();
        wr_t exp[$];
        bit ok; logic tk;
        wr_log.delete();
        pulse_start(1'b1);
        step();
        pulse_start(1'b0);
        repeat (3) step();
        exp = '{{3'd1, 16'h0007}};
        n_checks++;
        if (busy !== 1'b1 || !logs_equal(wr_log, exp))
            $display("FAIL start_busy_ignored: got busy=%b writes=%p required 1/%p", busy, wr_log, exp);
        else n_pass++;
        fire_irq(DATA_W'($urandom), ok, tk);
        n_checks++;
        if (!ok || busy !== 1'b1)
            $display("FAIL start_busy_mode_kept: got ok=%0d busy=%b required 1/1", ok, busy);
        else n_pass++;
        pulse_stop();
        repeat (3) step();
        exp = '{{3'd1, 16'h0007}, {3'd0, 16'h0}, {3'd4, 16'h0}, {3'd1, 16'h0008}};
        n_checks++;
        if (busy !== 1'b0 || !logs_equal(wr_log, exp))
            $display("FAIL start_busy_log: got busy=%b writes=%p required 0/%p", busy, wr_log, exp);
        else n_pass++;
    endtask

    task automatic test_idle_stop();
        wr_t exp[$];
        wr_log.delete();
        pulse_stop();
        repeat (3) step();
        n_checks++;
        if (busy !== 1'b0 || wr_log.size() != 0)
            $display("FAIL idle_stop_ignored: got busy=%b writes=%0d required 0/0", busy, wr_log.size());
        else n_pass++;
        pulse_start(1'b1);
        repeat (4) step();
        exp = '{{3'd1, 16'h0007}};
        n_checks++;
        if (busy !== 1'b1 || !logs_equal(wr_log, exp))
            $display("FAIL idle_stop_not_pending: got busy=%b writes=%p required 1/%p", busy, wr_log, exp);
        else n_pass++;
        pulse_stop();
        repeat (3) step();
    endtask

    task automatic test_random();
        wr_t exp[$];
        bit ok; logic tk;
        logic cont;
        int n;
        logic [DATA_W-1:0] val;
        for (int s = 0; s < 6; s++) begin
            wr_log.delete();
            exp.delete();
            cont = $urandom_range(0, 1);
            n    = cont ? $urandom_range(1, 4) : 1;
            pulse_start(cont);
            exp.push_back({3'd1, 13'h0, 1'b1, cont, 1'b1});
            for (int k = 1; k <= n; k++) begin
                val = DATA_W'($urandom);
                fire_irq(val, ok, tk);
                exp.push_back({3'd0, 16'h0});
                exp.push_back({3'd4, 16'h0});
                n_checks++;
                if (!ok || snapshot !== val)
                    $display("FAIL random_s%0d_t%0d: got ok=%0d snapshot=%h required 1/%h", s, k, ok, snapshot, val);
                else n_pass++;
            end
            if (cont) begin
                pulse_stop();
                repeat (3) step();
                exp.push_back({3'd1, 16'h0008});
            end
            n_checks++;
            if (busy !== 1'b0 || tick_count !== TICK_W'(n) || !logs_equal(wr_log, exp))
                $display("FAIL random_s%0d_end: got busy=%b tick_count=%0d writes=%p required 0/%0d/%p",
                         s, busy, tick_count, wr_log, n, exp);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_oneshot();
        test_stop_priority();
        test_reset_mid();
        test_start_busy();
        test_idle_stop();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
